// File: rtl/seven_seg_scan_reader.sv
// seven_seg_scan_reader
//   Receive side of a multiplexed 7-segment display. It watches the shared
//   segment lines and one-hot digit strobes and debounces each
//   strobe/pattern combination. Each stable digit is decoded back to its hex
//   code. A full frame is published once every digit has been captured.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   seg[6:0]     segment lines, bit0=a .. bit6=g
//   dig[D-1:0]   digit strobes, bit i selects digit i
//   value        last complete frame, nibble i = code of digit i
//   blank        digit i was dark in last frame
//   dig_err      digit i showed an unknown pattern in last frame
//   frame_valid  one-cycle pulse when value/blank/dig_err update
//   bus_err      sticky multi-hot strobe flag, cleared on frame_valid
//
// state  | meaning
// IDLE   | no digit selected, or multi-hot strobe; nothing to capture
// SETTLE | one-hot strobe, waiting for the combination to hold
// HELD   | combination captured; wait for the next change
module seven_seg_scan_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     dig_err,
  output logic                  frame_valid,
  output logic                  bus_err
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  // The counter holds (edges present - 1), so capture fires at STABLE-2.
  localparam logic [3:0] CAP_CNT = 4'(STABLE - 2);

  state_t                state, state_nxt;
  logic [6+DIGITS:0]     prev_combo;
  logic [3:0]            cnt;
  logic                  same, onehot, multi;
  logic                  capture;
  logic                  complete_pend;
  logic [DIGITS-1:0]     seen;
  logic [4*DIGITS-1:0]   sh_code;
  logic [DIGITS-1:0]     sh_blank;
  logic [DIGITS-1:0]     sh_err;
  logic [3:0]            dec_code;
  logic                  dec_blank, dec_err;

  assign same   = ({seg, dig} == prev_combo);
  assign onehot = $onehot(dig);
  assign multi  = !onehot && (|dig);

  always_comb begin
    dec_code  = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg)
      7'h3F: dec_code = 4'h0;
      7'h06: dec_code = 4'h1;
      7'h5B: dec_code = 4'h2;
      7'h4F: dec_code = 4'h3;
      7'h66: dec_code = 4'h4;
      7'h6D: dec_code = 4'h5;
      7'h7D: dec_code = 4'h6;
      7'h07: dec_code = 4'h7;
      7'h7F: dec_code = 4'h8;
      7'h6F: dec_code = 4'h9;
      7'h77: dec_code = 4'hA;
      7'h7C: dec_code = 4'hB;
      7'h39: dec_code = 4'hC;
      7'h5E: dec_code = 4'hD;
      7'h79: dec_code = 4'hE;
      7'h71: dec_code = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (onehot) state_nxt = SETTLE;
      SETTLE: begin
        if (!same)                 state_nxt = onehot ? SETTLE : IDLE;
        else if (cnt == CAP_CNT)   state_nxt = HELD;
      end
      HELD:    if (!same) state_nxt = onehot ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture = (state == SETTLE) && same && onehot && (cnt == CAP_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_combo <= '0;
      cnt        <= 4'd0;
    end else begin
      prev_combo <= {seg, dig};
      if (!same || multi)  cnt <= 4'd0;
      else if (cnt != 4'hF) cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen          <= '0;
      sh_code       <= '0;
      sh_blank      <= '0;
      sh_err        <= '0;
      complete_pend <= 1'b0;
      value         <= '0;
      blank         <= '1;
      dig_err       <= '0;
      frame_valid   <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      frame_valid   <= complete_pend;
      complete_pend <= capture && (&(seen | dig));
      if (complete_pend) begin
        value   <= sh_code;
        blank   <= sh_blank;
        dig_err <= sh_err;
      end
      if (capture) begin
        seen <= (complete_pend ? '0 : seen) | dig;
        for (int i = 0; i < DIGITS; i++) begin
          if (dig[i]) begin
            sh_code[4*i +: 4] <= dec_code;
            sh_blank[i]       <= dec_blank;
            sh_err[i]         <= dec_err;
          end
        end
      end else if (complete_pend) begin
        seen <= '0;
      end
      // set has priority over the frame-boundary clear
      if (multi)              bus_err <= 1'b1;
      else if (complete_pend) bus_err <= 1'b0;
    end
  end

endmodule

// File: doc/seven_seg_scan_reader.md
Name: seven_seg_scan_reader

Overview:
- Receive side of the multiplexed 7-segment display interface. Samples the shared segment lines and the one-hot digit strobes of a scanned DIGITS-digit display, then debounces each strobe/pattern combination.
- Maps each segment pattern back to its 4-bit hex code and publishes a complete frame (all digits) with a single-cycle valid pulse.
- Used by display loopback checks and front-panel readback.

Parameters:
- DIGITS, 4, number of scanned digits; width of dig and blank, value is 4*DIGITS bits.
- STABLE, 4, consecutive clock edges a strobe/pattern combination must hold before capture; legal range 2..15.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg  input  7  segment lines, active high, bit0=a … bit6=g; synchronous to clk.
- dig  input  DIGITS  digit strobes, active high, bit i selects digit i (digit 0 = least-significant nibble).
- value  output  4*DIGITS  last complete frame; nibble i = code of digit i.
- blank  output  DIGITS  bit i set: digit i was dark (seg=0x00) in last frame.
- dig_err  output  DIGITS  bit i set: digit i showed an unknown pattern in last frame.
- frame_valid  output  1  one-cycle pulse when value/blank/dig_err update.
- bus_err  output  1  sticky: multi-hot strobe seen since last frame.

Behaviour:
- Reset (async, immediate):
  - value=0, blank=all ones, dig_err=0, frame_valid=0, bus_err=0.
  - Stability counter=0, seen mask=0, shadow registers cleared, FSM=IDLE.
- Pattern table (seg hex → code):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - 00 → code 0 with blank bit set.
  - Any other pattern → code 0 with dig_err bit set.
- Stability:
  - Counter increments on each edge where {seg,dig} equals the value at the previous edge; it clears to 0 on any change.
  - Capture happens on the edge where the combination has been present for STABLE consecutive edges.
  - A combination held for STABLE-1 edges is never captured.
- Per-combination FSM:
  - IDLE: dig all-zero or multi-hot; no capture. Go to SETTLE when dig is one-hot.
  - SETTLE: counting. At the STABLE-th edge, write shadow code/blank/err for digit i, set seen[i], go to HELD.
  - HELD: no recapture. Any change of seg or dig → SETTLE if the new dig is one-hot, else IDLE.
- Frame completion:
  - Completes on the edge after the capture that makes seen all ones.
  - On that edge: value/blank/dig_err load from shadow (including the new capture), frame_valid=1 for exactly one cycle, seen clears.
  - Latency from first cycle of the completing combination: STABLE+1 edges.
- Recapture within a frame: the same digit captured again before the frame completes overwrites its shadow entry; the latest capture wins.
- Multi-hot dig: no capture, counter clears, bus_err set.
  - bus_err clears on a frame_valid edge.
  - If a set and a clear occur on the same edge, set wins.
- Frame boundary: outputs hold between frames. A partial frame never updates the outputs.
- Reset mid-frame: all partial captures are discarded and the outputs return to their reset values.

Test Plan:
- Reset then scan 3F,06,5B,4F on dig=1,2,4,8, each held 6 cycles → one frame_valid pulse; value=0x3210, blank=0, dig_err=0, bus_err=0.
- Same scan with every hold exactly 3 cycles (STABLE=4) → no frame_valid; value=0, blank=4'b1111.
- Scan 79,00,2A,71 on digits 0..3 → value=0xF00E, blank=4'b0010, dig_err=4'b0100.
- Full scan in which digit 2 is captured as 6D and then recaptured as 07 before digit 3 completes → value nibble 2 = 7.
- Insert dig=4'b0011 for 5 cycles mid-scan, then complete the scan → bus_err=1 until the frame_valid edge, then 0. Frame data is unaffected.
- Assert rst after 3 of 4 digits are captured, release, then scan digit 3 only → no frame_valid; outputs stay at reset values.
